// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD SPI receiver.
//   lcd_state_t  decoder state encoding (driven on lcd_spi_rx.state)
//   CMD_*        command opcodes recognised by the decoder
//   *_RST        window register reset values
//   win9()       builds a 9-bit window coordinate from a high/low parameter pair
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_RASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } lcd_state_t;

  localparam logic [7:0] CMD_SLPIN  = 8'h10;
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_INVOFF = 8'h20;
  localparam logic [7:0] CMD_INVON  = 8'h21;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON = 8'h29;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  localparam logic [8:0] XS_RST = 9'd0;
  localparam logic [8:0] XE_RST = 9'd239;
  localparam logic [8:0] YS_RST = 9'd0;
  localparam logic [8:0] YE_RST = 9'd134;

  // Only bit 0 of the high parameter byte is meaningful for a 9-bit coordinate.
  function automatic logic [8:0] win9(input logic hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/lcd_spi_shift.sv
// lcd_spi_shift: SPI byte receiver front end.
//   clk, reset            system clock, async active-high reset
//   lcd_clk/cs/rs/data    raw SPI pins, synchronised by SYNC_STAGES flops each
//   byte_valid            one-cycle strobe, byte_data/byte_is_data valid with it
//   frame_err             one-cycle strobe when cs rises with a partial byte
module lcd_spi_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_clk,
  input  logic       lcd_cs,
  input  logic       lcd_rs,
  input  logic       lcd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rs_sync;
  logic [SYNC_STAGES-1:0] data_sync;

  logic       sclk_s, cs_s, rs_s, data_s;
  logic       sclk_q, cs_q;
  logic       sclk_rise, cs_rise, shift_en;
  logic [2:0] bit_cnt, cnt_next;
  logic [7:0] shifter;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rs_s   = rs_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  // An edge landing in the same cycle as cs rising still belongs to the frame,
  // so a byte completed by it is delivered rather than flagged.
  assign shift_en  = sclk_rise & (~cs_s | cs_rise);
  assign cnt_next  = shift_en ? bit_cnt + 3'd1 : bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync    <= '0;
      cs_sync      <= '0;
      rs_sync      <= '0;
      data_sync    <= '0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b0;
      bit_cnt      <= 3'd0;
      shifter      <= 8'd0;
      byte_valid   <= 1'b0;
      byte_data    <= 8'd0;
      byte_is_data <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], lcd_clk};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], lcd_cs};
      rs_sync    <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], lcd_data};
      sclk_q     <= sclk_s;
      cs_q       <= cs_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (shift_en) begin
        shifter <= {shifter[6:0], data_s};
      end
      if (shift_en && bit_cnt == 3'd7) begin
        byte_valid   <= 1'b1;
        byte_data    <= {shifter[6:0], data_s};
        byte_is_data <= rs_s;
      end

      if (cs_rise) begin
        bit_cnt   <= 3'd0;
        frame_err <= (cnt_next != 3'd0);
      end else if (cs_s) begin
        bit_cnt <= 3'd0;
      end else begin
        bit_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: LCD controller SPI receiver with command decoder.
//   clk, reset                     system clock, async active-high reset
//   lcd_clk/cs/rs/data             SPI pins (f_clk >= 4 x f_sclk)
//   byte_valid/byte_data/is_data   raw received byte strobe
//   pix_valid/pix_data/pix_x/pix_y RGB565 pixel strobe with coordinates
//   sleep_out/disp_on/inv_on       display status flags
//   frame_err                      partial byte discarded on cs rise
//   state                          decoder state (lcd_state_t)
//
// state    | meaning
// IDLE     | no command in progress, data bytes ignored
// CASET    | collecting 4 column window parameters
// RASET    | collecting 4 row window parameters
// RAMWR    | streaming pixel bytes, hi then lo
// SKIP     | unknown command, data ignored until next command
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_clk,
  input  logic        lcd_cs,
  input  logic        lcd_rs,
  input  logic        lcd_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        sleep_out,
  output logic        disp_on,
  output logic        inv_on,
  output logic        frame_err,
  output logic [2:0]  state
);

  lcd_state_t state_q, state_d;

  logic       is_cmd, is_dat;
  logic [1:0] param_cnt;
  logic       hi_tmp;
  logic       half;
  logic [7:0] pix_hi;
  logic [8:0] xs, xe, ys, ye;
  logic [8:0] cur_x, cur_y;

  lcd_spi_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .clk          (clk),
    .reset        (reset),
    .lcd_clk      (lcd_clk),
    .lcd_cs       (lcd_cs),
    .lcd_rs       (lcd_rs),
    .lcd_data     (lcd_data),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .frame_err    (frame_err)
  );

  assign is_cmd = byte_valid & ~byte_is_data;
  assign is_dat = byte_valid & byte_is_data;
  assign state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_cmd) begin
      case (byte_data)
        CMD_CASET: state_d = ST_CASET;
        CMD_RASET: state_d = ST_RASET;
        CMD_RAMWR: state_d = ST_RAMWR;
        CMD_SLPIN, CMD_SLPOUT, CMD_INVOFF, CMD_INVON,
        CMD_DISPOFF, CMD_DISPON: state_d = ST_IDLE;
        default: state_d = ST_SKIP;
      endcase
    end else if (is_dat) begin
      case (state_q)
        ST_CASET, ST_RASET: if (param_cnt == 2'd3) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      param_cnt <= 2'd0;
      hi_tmp    <= 1'b0;
      half      <= 1'b0;
      pix_hi    <= 8'd0;
      xs        <= XS_RST;
      xe        <= XE_RST;
      ys        <= YS_RST;
      ye        <= YE_RST;
      cur_x     <= 9'd0;
      cur_y     <= 9'd0;
      pix_valid <= 1'b0;
      pix_data  <= 16'd0;
      pix_x     <= 9'd0;
      pix_y     <= 9'd0;
      sleep_out <= 1'b0;
      disp_on   <= 1'b0;
      inv_on    <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (is_cmd) begin
        // Any command aborts parameter collection and drops a pending hi byte.
        param_cnt <= 2'd0;
        half      <= 1'b0;
        case (byte_data)
          CMD_SLPOUT:  sleep_out <= 1'b1;
          CMD_SLPIN:   sleep_out <= 1'b0;
          CMD_DISPON:  disp_on   <= 1'b1;
          CMD_DISPOFF: disp_on   <= 1'b0;
          CMD_INVON:   inv_on    <= 1'b1;
          CMD_INVOFF:  inv_on    <= 1'b0;
          CMD_RAMWR: begin
            cur_x <= xs;
            cur_y <= ys;
          end
          default: ;
        endcase
      end else if (is_dat) begin
        case (state_q)
          ST_CASET, ST_RASET: begin
            param_cnt <= param_cnt + 2'd1;
            case (param_cnt)
              2'd0, 2'd2: hi_tmp <= byte_data[0];
              2'd1: if (state_q == ST_CASET) xs <= win9(hi_tmp, byte_data);
                    else                     ys <= win9(hi_tmp, byte_data);
              default: if (state_q == ST_CASET) xe <= win9(hi_tmp, byte_data);
                       else                     ye <= win9(hi_tmp, byte_data);
            endcase
          end
          ST_RAMWR: begin
            if (!half) begin
              pix_hi <= byte_data;
              half   <= 1'b1;
            end else begin
              half      <= 1'b0;
              pix_valid <= 1'b1;
              pix_data  <= {pix_hi, byte_data};
              pix_x     <= cur_x;
              pix_y     <= cur_y;
              // Outside-window cursors just wrap at 9 bits until they meet xe/ye.
              if (cur_x == xe) begin
                cur_x <= xs;
                cur_y <= (cur_y == ye) ? ys : cur_y + 9'd1;
              end else begin
                cur_x <= cur_x + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on every SPI input (legal 2..4).
REQ-002 SHALL have port clk, input, 1, system clock; one clock only; f_clk >= 4 x f_sclk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port lcd_clk, input, 1, SPI clock; data sampled on rising edge.
REQ-005 SHALL have port lcd_cs, input, 1, chip select, active low.
REQ-006 SHALL have port lcd_rs, input, 1, 0 = command byte, 1 = data/parameter byte.
REQ-007 SHALL have port lcd_data, input, 1, serial data, MSB first.
REQ-008 SHALL have outputs byte_valid (1), byte_data (8) and byte_is_data (1): one-cycle strobe with the received byte and its lcd_rs value.
REQ-009 SHALL have outputs pix_valid (1), pix_data (16), pix_x (9) and pix_y (9): one-cycle strobe per RGB565 pixel with its coordinates.
REQ-010 SHALL have outputs sleep_out (1), disp_on (1), inv_on (1), frame_err (1) and state (3).

Function
REQ-011 SHALL pass lcd_clk, lcd_cs, lcd_rs and lcd_data through SYNC_STAGES flops and detect a rising edge as synced lcd_clk 0 then 1.
REQ-012 SHALL, on each rising edge while synced lcd_cs=0, shift lcd_data into the LSB of an 8-bit shifter and increment a 3-bit bit counter.
REQ-013 SHALL, on the 8th edge, capture lcd_rs and assert byte_valid for exactly one clk, with byte_data valid in that same cycle.
REQ-014 SHALL clear the bit counter when synced lcd_cs goes high; if the count is 1..7, the partial byte is discarded and frame_err pulses for 1 clk.
REQ-015 SHALL run a decoder FSM with states IDLE, CASET, RASET, RAMWR and SKIP, encoded on output state.
REQ-016 SHALL, on any command byte in any state, abort the current state, clear the parameter counter and the pixel half-byte flag, then decode the new command.
REQ-017 SHALL decode commands as follows: 0x2A -> CASET, 0x2B -> RASET, 0x2C -> RAMWR, 0x11 sets sleep_out, 0x10 clears sleep_out, 0x29/0x28 set/clear disp_on, 0x21/0x20 set/clear inv_on; all of these except CASET/RASET/RAMWR return to IDLE.
REQ-018 SHALL send any other command to SKIP, which ignores data bytes until the next command.
REQ-019 SHALL, in CASET/RASET, take 4 parameters in the order start high, start low, end high, end low; the window register is {high[0], low} (9 bits), and the state returns to IDLE after the 4th parameter.
REQ-020 SHALL ignore data bytes received in IDLE.
REQ-021 SHALL, on entry to RAMWR, load the cursor to (xs, ys).
REQ-022 SHALL, in RAMWR, latch each even data byte as the pixel high byte; each odd data byte completes the pixel.
REQ-023 SHALL assert pix_valid one clk after the odd byte's byte_valid, with pix_data={hi,lo} and pix_x/pix_y equal to the cursor before advance.
REQ-024 SHALL advance the cursor as follows: x==xe -> x=xs and y advances, else x+1; y==ye -> y=ys, else y+1.
REQ-025 SHALL keep a cursor outside the window (xs>xe or ys>ye) incrementing with 9-bit wrap and SHALL NOT lock up.
REQ-026 SHALL discard a pending high byte when a command byte arrives mid-pixel, with no pix_valid.
REQ-027 SHALL give byte completion priority when it coincides with lcd_cs rising in the same clk, so the byte is delivered.

Reset
REQ-028 SHALL, on reset, set all outputs, window registers (xs=0, xe=239, ys=0, ye=134), cursor, counters and synchronizers to 0 except the listed window ends; the state SHALL be IDLE.
REQ-029 SHALL let reset assertion mid-byte or mid-pixel abort it immediately, with no strobe after release until a fresh 8-edge byte.

Structure
REQ-030 SHALL place in shared package lcd_pkg the state encoding, command opcodes (0x11, 0x10, 0x20, 0x21, 0x28, 0x29, 0x2A, 0x2B, 0x2C) and window reset constants.
REQ-031 SHALL implement sub-module lcd_spi_shift (synchronizers, edge detect, shifter, byte strobe); decoder FSM in lcd_spi_rx.

Verification
REQ-032 SHALL verify: byte 0x11 with rs=0 at sclk=clk/4 -> one byte_valid, byte_data=0x11, byte_is_data=0, sleep_out=1.
REQ-033 SHALL verify: 2A 00 28 01 17, then 2B 00 35 00 BB, then 2C -> xs=40, xe=279 mod 512, ys=53, ye=187, state=RAMWR, cursor (40,53).
REQ-034 SHALL verify: window xs=0 xe=1 ys=0 ye=1, then 2C and 10 bytes F0 34 repeated -> 5 pix_valid, data 0xF034, coords (0,0),(1,0),(0,1),(1,1),(0,0).
REQ-035 SHALL verify: cs rises after 5 bits -> frame_err pulse, no byte_valid; the next full byte 0xA5 is received correctly.
REQ-036 SHALL verify: in RAMWR, a single data byte then command 0x29 -> no pix_valid, disp_on=1, state=IDLE.
REQ-037 SHALL verify: reset asserted after the 6th bit of a byte, then released -> all outputs 0, state=IDLE, no strobe until the next full byte.
